// File: rtl/ldmstm_sequencer_pkg.sv
// Shared constants for the LDM/STM block-transfer sequencer.
//   - FSM state encodings (LDMSTM_IDLE/CALC/XFER/DONE)
//   - Instruction bit positions of the P/U/S/W/L flags
//   - Block-transfer decode pattern for insn[27:25]
//   - Helper that scales a register count to a byte offset
package ldmstm_sequencer_pkg;

    localparam logic [1:0] LDMSTM_IDLE = 2'd0;
    localparam logic [1:0] LDMSTM_CALC = 2'd1;
    localparam logic [1:0] LDMSTM_XFER = 2'd2;
    localparam logic [1:0] LDMSTM_DONE = 2'd3;

    localparam int LDMSTM_P = 24;
    localparam int LDMSTM_U = 23;
    localparam int LDMSTM_S = 22;
    localparam int LDMSTM_W = 21;
    localparam int LDMSTM_L = 20;

    // insn[27:25] of every LDM/STM encoding
    localparam logic [2:0] DECODE_LDMSTM = 3'b100;

    // Byte offset covered by n word transfers (4*n)
    function automatic logic [31:0] word_offset(input logic [4:0] n);
        return {25'd0, n, 2'b00};
    endfunction

endpackage

// File: rtl/ldmstm_sequencer_if.sv
// Decode-to-sequencer-to-memory signal bundle for ldmstm_sequencer.
//   master : sequencer side (takes start/insn/base/flush/step_ready,
//            drives busy, step_*, done, wb_*)
//   slave  : pipeline/memory side, directions mirrored
interface ldmstm_sequencer_if;

    logic        start;
    logic [31:0] insn;
    logic [31:0] base;
    logic        flush;
    logic        busy;
    logic        step_valid;
    logic        step_ready;
    logic [3:0]  step_reg;
    logic [31:0] step_addr;
    logic        step_load;
    logic        step_user;
    logic        step_last;
    logic        done;
    logic        wb_valid;
    logic [3:0]  wb_reg;
    logic [31:0] wb_data;

    modport master (
        input  start, insn, base, flush, step_ready,
        output busy, step_valid, step_reg, step_addr, step_load,
               step_user, step_last, done, wb_valid, wb_reg, wb_data
    );

    modport slave (
        output start, insn, base, flush, step_ready,
        input  busy, step_valid, step_reg, step_addr, step_load,
               step_user, step_last, done, wb_valid, wb_reg, wb_data
    );

endinterface

// File: rtl/ldmstm_sequencer_lowest_set_bit16.sv
// Priority encoder: index of the lowest set bit of a 16-bit mask.
//   mask  in  16  bit mask
//   index out 4   lowest set bit position (0 when mask is empty)
//   none  out 1   mask is all zeros
module lowest_set_bit16
    import ldmstm_sequencer_pkg::*;
(
    input  logic [15:0] mask,
    output logic [3:0]  index,
    output logic        none
);

    // Scan from the top down so the lowest set bit is written last
    always_comb begin
        index = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            index = mask[i] ? i[3:0] : index;
        end
        none = (mask == 16'd0);
    end

endmodule

// File: rtl/ldmstm_sequencer.sv
// ARM LDM/STM sequencer: walks the register list in ascending order and
// issues one register/address step per cycle to the memory stage, then
// reports the base writeback value.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : ldmstm_sequencer_if.master (start/insn/base/flush in,
//              step handshake out/in, busy/done/writeback out)
// Optional feature: define LDMSTM_USER_BANK_EN to drive step_user from the
// S bit; otherwise step_user is tied low.
module ldmstm_sequencer
    import ldmstm_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    ldmstm_sequencer_if.master   bus
);

    logic [1:0]  state_r, state_seq_s, state_next_s;
    logic [15:0] mask_r, mask_next_s;
    logic [31:0] base_r, wb_calc_r, wb_calc_s, wb_done_s;
    logic [31:0] start_addr_s, addr_next_s, four_n_s;
    logic [3:0]  rn_r, lsb_idx_s;
    logic        p_r, u_r, w_r, l_r, user_r, user_s;
    logic [4:0]  pop_s;
    logic        fire_s, xfer_next_s, done_next_s, one_left_s, lsb_none_s;
    logic        unused_s;

    logic        busy_r, step_valid_r, step_load_r, step_user_r, step_last_r;
    logic [3:0]  step_reg_r, wb_reg_r;
    logic [31:0] step_addr_r, wb_data_r;
    logic        done_r, wb_valid_r;

    lowest_set_bit16 u_lsb (
        .mask  (mask_next_s),
        .index (lsb_idx_s),
        .none  (lsb_none_s)
    );

`ifdef LDMSTM_USER_BANK_EN
    // LDM with r15 restores CPSR downstream and uses the current bank
    assign user_s   = bus.insn[LDMSTM_S] & ~(bus.insn[LDMSTM_L] & bus.insn[15]);
    assign unused_s = ^{bus.insn[31:25], lsb_none_s};
`else
    assign user_s   = 1'b0;
    assign unused_s = ^{bus.insn[31:25], bus.insn[LDMSTM_S], lsb_none_s};
`endif

    // Popcount, start address and writeback value; mask_r holds the full list in CALC
    always_comb begin
        pop_s = 5'd0;
        for (int i = 0; i < 16; i++) begin
            pop_s = pop_s + {4'd0, mask_r[i]};
        end
        four_n_s = word_offset(pop_s);
        case ({p_r, u_r})
            2'b01:   start_addr_s = base_r;                        // IA
            2'b11:   start_addr_s = base_r + 32'd4;                // IB
            2'b00:   start_addr_s = base_r - four_n_s + 32'd4;     // DA
            2'b10:   start_addr_s = base_r - four_n_s;             // DB
            default: start_addr_s = base_r;
        endcase
        wb_calc_s = u_r ? (base_r + four_n_s) : (base_r - four_n_s);
        // Empty list jumps CALC->DONE before wb_calc_r has been loaded
        wb_done_s = (state_r == LDMSTM_CALC) ? wb_calc_s : wb_calc_r;
    end

    // Next state, remaining mask and next step address
    always_comb begin
        fire_s       = step_valid_r & bus.step_ready;
        state_seq_s  = state_r;
        mask_next_s  = mask_r;
        addr_next_s  = step_addr_r;
        case (state_r)
            LDMSTM_IDLE: begin
                if (bus.start) begin
                    state_seq_s = LDMSTM_CALC;
                    mask_next_s = bus.insn[15:0];
                end else begin
                    state_seq_s = LDMSTM_IDLE;
                end
            end
            LDMSTM_CALC: begin
                addr_next_s = start_addr_s;
                state_seq_s = (pop_s == 5'd0) ? LDMSTM_DONE : LDMSTM_XFER;
            end
            LDMSTM_XFER: begin
                if (fire_s) begin
                    mask_next_s = mask_r & (mask_r - 16'd1);   // drop lowest bit
                    addr_next_s = step_addr_r + 32'd4;
                    state_seq_s = step_last_r ? LDMSTM_DONE : LDMSTM_XFER;
                end else begin
                    state_seq_s = LDMSTM_XFER;
                end
            end
            LDMSTM_DONE: state_seq_s = LDMSTM_IDLE;
            default:     state_seq_s = LDMSTM_IDLE;
        endcase
        state_next_s = bus.flush ? LDMSTM_IDLE : state_seq_s;
        xfer_next_s  = (state_next_s == LDMSTM_XFER);
        done_next_s  = (state_next_s == LDMSTM_DONE);
        one_left_s   = (mask_next_s != 16'd0) &&
                       ((mask_next_s & (mask_next_s - 16'd1)) == 16'd0);
    end

    // State, latched instruction fields and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= LDMSTM_IDLE;
            mask_r       <= 16'd0;
            base_r       <= 32'd0;
            rn_r         <= 4'd0;
            p_r          <= 1'b0;
            u_r          <= 1'b0;
            w_r          <= 1'b0;
            l_r          <= 1'b0;
            user_r       <= 1'b0;
            wb_calc_r    <= 32'd0;
            busy_r       <= 1'b0;
            step_valid_r <= 1'b0;
            step_reg_r   <= 4'd0;
            step_addr_r  <= 32'd0;
            step_load_r  <= 1'b0;
            step_user_r  <= 1'b0;
            step_last_r  <= 1'b0;
            done_r       <= 1'b0;
            wb_valid_r   <= 1'b0;
            wb_reg_r     <= 4'd0;
            wb_data_r    <= 32'd0;
        end else begin
            state_r <= state_next_s;
            mask_r  <= bus.flush ? 16'd0 : mask_next_s;
            if ((state_r == LDMSTM_IDLE) && bus.start && !bus.flush) begin
                base_r <= bus.base;
                rn_r   <= bus.insn[19:16];
                p_r    <= bus.insn[LDMSTM_P];
                u_r    <= bus.insn[LDMSTM_U];
                w_r    <= bus.insn[LDMSTM_W];
                l_r    <= bus.insn[LDMSTM_L];
                user_r <= user_s;
            end
            if (state_r == LDMSTM_CALC) begin
                wb_calc_r <= wb_calc_s;
            end
            busy_r       <= (state_next_s != LDMSTM_IDLE);
            step_valid_r <= xfer_next_s;
            step_reg_r   <= xfer_next_s ? lsb_idx_s : 4'd0;
            step_addr_r  <= xfer_next_s ? addr_next_s : 32'd0;
            step_load_r  <= xfer_next_s & l_r;
            step_user_r  <= xfer_next_s & user_r;
            step_last_r  <= xfer_next_s & one_left_s;
            done_r       <= done_next_s;
            wb_valid_r   <= done_next_s & w_r;
            wb_reg_r     <= done_next_s ? rn_r : 4'd0;
            wb_data_r    <= done_next_s ? wb_done_s : 32'd0;
        end
    end

    assign bus.busy       = busy_r;
    assign bus.step_valid = step_valid_r;
    assign bus.step_reg   = step_reg_r;
    assign bus.step_addr  = step_addr_r;
    assign bus.step_load  = step_load_r;
    assign bus.step_user  = step_user_r;
    assign bus.step_last  = step_last_r;
    assign bus.done       = done_r;
    assign bus.wb_valid   = wb_valid_r;
    assign bus.wb_reg     = wb_reg_r;
    assign bus.wb_data    = wb_data_r;

endmodule
